// File: rtl/sd_stream_pkg.sv
// Shared definitions for the SD audio streaming scheduler.
//   state_e         : sequencer states
//   BLOCK_BYTES     : bytes per SD block read
//   WORDS_PER_BLOCK : 16-bit PCM words produced per block
package sd_stream_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SPACE,
    ISSUE,
    RECV,
    NEXT,
    DONE
  } state_e;

  localparam int unsigned BLOCK_BYTES     = 512;
  localparam int unsigned WORDS_PER_BLOCK = 256;

endpackage

// File: rtl/sd_stream_sched_sample_pacer.sv
// Sample-rate pacer: a counter cycling 0..SAMPLE_DIV-1 while 'run' is high.
// On each wrap it either reads one FIFO word (fifo_rd_en for one cycle, then
// pcm_valid the cycle after, matching the FIFO's 1-cycle read latency) or,
// if the FIFO is empty, bumps a saturating underrun counter.
//   clk, rst_n      : clock, asynchronous active-low reset
//   run             : counter advances while high
//   fifo_empty      : FIFO empty flag
//   fifo_rd_en      : FIFO read strobe
//   pcm_valid       : FIFO dout holds a fresh sample
//   underrun_count  : saturating count of ticks that found the FIFO empty
module sample_pacer #(
  parameter int unsigned SAMPLE_DIV = 567
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  output logic        pcm_valid,
  output logic [15:0] underrun_count
);

  localparam int unsigned CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          rd_q, rd_d;
  logic          valid_q, valid_d;
  logic [15:0]   und_q, und_d;
  logic          tick;

  always_comb begin
    cnt_d   = cnt_q;
    tick    = 1'b0;
    rd_d    = 1'b0;
    valid_d = rd_q;
    und_d   = und_q;
    if (run) begin
      if (cnt_q == CW'(SAMPLE_DIV - 1)) begin
        cnt_d = '0;
        tick  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    if (tick) begin
      if (!fifo_empty) begin
        rd_d = 1'b1;
      end else if (und_q != '1) begin
        und_d = und_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      valid_q <= 1'b0;
      und_q   <= '0;
    end else begin
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      valid_q <= valid_d;
      und_q   <= und_d;
    end
  end

  assign fifo_rd_en     = rd_q;
  assign pcm_valid      = valid_q;
  assign underrun_count = und_q;

endmodule

// File: rtl/sd_stream_sched.sv
// SD audio streaming scheduler: issues 512-byte block reads to sd_controller,
// packs returned bytes little-endian into 16-bit PCM words for the audio FIFO,
// and paces FIFO reads at the sample rate for PCMtoPWM.
// Optional feature macro: SD_STREAM_LOOP_EN (wrap to START_ADDR past END_ADDR
// instead of stopping in DONE; done is then tied low).
//   clk, rst_n                  : 25 MHz clock, asynchronous active-low reset
//   enable                      : 1 = stream, 0 = stop after current block
//   sd_ready, sd_byte_available, sd_dout : sd_controller status / read data
//   sd_rd, sd_address           : block read command and byte address
//   fifo_full, fifo_empty, fifo_data_count : FIFO status
//   fifo_din, fifo_wr_en        : packed PCM word and write strobe
//   fifo_rd_en, pcm_valid       : paced FIFO read strobe / sample valid
//   busy, done, overflow, underrun_count : status
module sd_stream_sched
  import sd_stream_pkg::*;
#(
  parameter logic [31:0] START_ADDR = 32'h0000_0000,
  parameter logic [31:0] END_ADDR   = 32'h0010_0000,
  parameter int unsigned FIFO_DEPTH = 8192,
  parameter int unsigned FIFO_CNT_W = 14,
  parameter int unsigned SAMPLE_DIV = 567
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  sd_ready,
  input  logic                  sd_byte_available,
  input  logic [7:0]            sd_dout,
  output logic                  sd_rd,
  output logic [31:0]           sd_address,
  input  logic                  fifo_full,
  input  logic                  fifo_empty,
  input  logic [FIFO_CNT_W-1:0] fifo_data_count,
  output logic [15:0]           fifo_din,
  output logic                  fifo_wr_en,
  output logic                  fifo_rd_en,
  output logic                  pcm_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [15:0]           underrun_count
);

  state_e      state_q, state_d;
  logic        sd_rd_q, sd_rd_d;
  logic [31:0] addr_q, addr_d;
  logic [9:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]  low_q, low_d;
  logic        avail_q, avail_d;
  logic [15:0] din_q, din_d;
  logic        wr_q, wr_d;
  logic        ovf_q, ovf_d;

  logic        byte_stb;
  logic        space_ok;
  logic [32:0] next_addr;

  always_comb begin
    state_d    = state_q;
    sd_rd_d    = 1'b0;
    addr_d     = addr_q;
    byte_cnt_d = byte_cnt_q;
    low_d      = low_q;
    avail_d    = sd_byte_available;
    din_d      = din_q;
    wr_d       = 1'b0;
    ovf_d      = ovf_q;

    // The byte strobe is a level that may span several cycles; capture on its rising edge only.
    byte_stb  = sd_byte_available & ~avail_q;
    // 33-bit sum so an address near 2^32 cannot wrap and pass the END_ADDR test.
    next_addr = {1'b0, addr_q} + 33'(BLOCK_BYTES);
    space_ok  = 32'(fifo_data_count) <= 32'(FIFO_DEPTH - WORDS_PER_BLOCK);

    unique case (state_q)
      IDLE: begin
        if (enable) state_d = WAIT_SPACE;
      end
      WAIT_SPACE: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (sd_ready && space_ok) begin
          state_d = ISSUE;
          sd_rd_d = 1'b1;
        end
      end
      ISSUE: begin
        byte_cnt_d = '0;
        if (sd_ready) sd_rd_d = 1'b1;
        else          state_d = RECV;
      end
      RECV: begin
        if (byte_stb && byte_cnt_q != 10'(BLOCK_BYTES)) begin
          byte_cnt_d = byte_cnt_q + 10'd1;
          if (!byte_cnt_q[0]) begin
            low_d = sd_dout;
          end else if (fifo_full) begin
            ovf_d = 1'b1;
          end else begin
            wr_d  = 1'b1;
            din_d = {sd_dout, low_q};
          end
        end
        if (byte_cnt_q == 10'(BLOCK_BYTES) && sd_ready) state_d = NEXT;
      end
      NEXT: begin
        byte_cnt_d = '0;
        if (next_addr <= {1'b0, END_ADDR}) begin
          addr_d  = next_addr[31:0];
          state_d = enable ? WAIT_SPACE : IDLE;
        end else begin
`ifdef SD_STREAM_LOOP_EN
          addr_d  = START_ADDR;
          state_d = enable ? WAIT_SPACE : IDLE;
`else
          state_d = DONE;
`endif
        end
      end
      DONE: begin
        if (!enable) begin
          state_d = IDLE;
          addr_d  = START_ADDR;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sd_rd_q    <= 1'b0;
      addr_q     <= START_ADDR;
      byte_cnt_q <= '0;
      low_q      <= '0;
      avail_q    <= 1'b0;
      din_q      <= '0;
      wr_q       <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sd_rd_q    <= sd_rd_d;
      addr_q     <= addr_d;
      byte_cnt_q <= byte_cnt_d;
      low_q      <= low_d;
      avail_q    <= avail_d;
      din_q      <= din_d;
      wr_q       <= wr_d;
      ovf_q      <= ovf_d;
    end
  end

  sample_pacer #(
    .SAMPLE_DIV(SAMPLE_DIV)
  ) u_pacer (
    .clk           (clk),
    .rst_n         (rst_n),
    .run           ((state_q != IDLE) | ~fifo_empty),
    .fifo_empty    (fifo_empty),
    .fifo_rd_en    (fifo_rd_en),
    .pcm_valid     (pcm_valid),
    .underrun_count(underrun_count)
  );

  assign sd_rd      = sd_rd_q;
  assign sd_address = addr_q;
  assign fifo_din   = din_q;
  assign fifo_wr_en = wr_q;
  assign overflow   = ovf_q;
  assign busy       = (state_q != IDLE) && (state_q != DONE);
`ifdef SD_STREAM_LOOP_EN
  assign done       = 1'b0;
`else
  assign done       = (state_q == DONE);
`endif

endmodule

// File: doc/sd_stream_sched.md
Name: sd_stream_sched

Overview:
- Sequences block reads from the SD controller for audio playback.
- Packs the returned bytes into 16-bit PCM words and pushes them into the audio FIFO.
- Paces FIFO reads at the audio sample rate to feed PCMtoPWM.
- Sits between sd_controller, the FIFO generator and PCMtoPWM on the 25 MHz domain; replaces ad-hoc read/pack logic at top level.

Parameters:
- START_ADDR, 32'h0000_0000, byte address of the first 512-byte block
- END_ADDR, 32'h0010_0000, last valid block start address (inclusive)
- FIFO_DEPTH, 8192, FIFO capacity in 16-bit words
- FIFO_CNT_W, 14, width of fifo_data_count
- SAMPLE_DIV, 567, clk cycles per PCM sample (25 MHz / 567 ≈ 44.1 kHz)

Ports:
- clk  in  1  system clock (25 MHz)
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  level; 1 = stream, 0 = stop after the current block
- sd_ready  in  1  sd_controller idle/accepting commands
- sd_byte_available  in  1  sd_controller byte strobe (level, may last >1 cycle)
- sd_dout  in  8  sd_controller read byte
- sd_rd  out  1  read command to sd_controller
- sd_address  out  32  block byte address to sd_controller
- fifo_full  in  1  FIFO full flag
- fifo_empty  in  1  FIFO empty flag
- fifo_data_count  in  FIFO_CNT_W  FIFO occupancy in words
- fifo_din  out  16  packed PCM word
- fifo_wr_en  out  1  FIFO write strobe
- fifo_rd_en  out  1  FIFO read strobe
- pcm_valid  out  1  one-cycle pulse: FIFO dout is a fresh sample
- busy  out  1  state != IDLE and state != DONE
- done  out  1  end of stream reached (no-loop build only)
- overflow  out  1  sticky: a word was dropped because the FIFO was full
- underrun_count  out  16  saturating count of sample ticks that found the FIFO empty

Behaviour:
- Reset (async, rst_n=0):
  - state = IDLE; sd_rd = 0; sd_address = START_ADDR.
  - fifo_wr_en = fifo_rd_en = pcm_valid = 0; fifo_din = 0.
  - busy = done = overflow = 0; underrun_count = 0.
  - Byte counter, pack phase and pace counter cleared.
  - Reset mid-block abandons the block; the SD card is re-sequenced by the sd_controller's own reset.
- States:
  - IDLE: if enable -> WAIT_SPACE.
  - WAIT_SPACE:
    - If !enable -> IDLE.
    - Otherwise, when sd_ready and fifo_data_count <= FIFO_DEPTH-256 -> ISSUE.
  - ISSUE: sd_rd = 1; hold until sd_ready = 0, then sd_rd = 0 on the next cycle -> RECV.
  - RECV:
    - Each rising edge of sd_byte_available captures sd_dout.
    - Even byte count: low byte; odd byte count: high byte, then a fifo_wr_en pulse with fifo_din = {high, low} (little-endian).
    - After 512 bytes and sd_ready = 1 -> NEXT.
  - NEXT (1 cycle):
    - If sd_address + 512 <= END_ADDR, sd_address += 512.
    - Else: wrap or DONE, per optional feature.
    - Then -> WAIT_SPACE if enable, else IDLE.
  - DONE: done = 1; leaves only on reset or when enable falls (-> IDLE, sd_address = START_ADDR).
- enable deasserted in ISSUE/RECV: the current block completes, then IDLE. An SD read is never aborted.
- FIFO write when fifo_full=1:
  - Word dropped, fifo_wr_en stays 0, overflow set.
  - Cannot occur when the threshold is respected.
- Pacer:
  - Free-running 0..SAMPLE_DIV-1, running whenever state != IDLE or the FIFO is non-empty.
  - Tick at wrap:
    - fifo_empty = 0: one-cycle fifo_rd_en; pcm_valid pulses on the following cycle (1-cycle FIFO read latency).
    - fifo_empty = 1: no read; underrun_count += 1, saturating at 16'hFFFF.
- Writes and reads in the same cycle are independent; the FIFO handles concurrency.
- Only one SD command is ever outstanding.

Optional Feature:
- Macro SD_STREAM_LOOP_EN.
- Defined: in NEXT, address beyond END_ADDR wraps to START_ADDR; streaming continues indefinitely; done is tied 0.
- Undefined: address beyond END_ADDR goes to DONE; done = 1; the pacer drains the remaining FIFO contents.

Decomposition:
- Package sd_stream_pkg holds:
  - state enum (IDLE, WAIT_SPACE, ISSUE, RECV, NEXT, DONE)
  - BLOCK_BYTES = 512
  - WORDS_PER_BLOCK = 256
- Sub-module sample_pacer (SAMPLE_DIV counter, fifo_rd_en/pcm_valid generation, underrun counter).
- Sequencer FSM and byte packer stay in the top.

Test Plan:
- Reset, enable = 1, SD model returning bytes 0x00..0xFF repeating -> first FIFO words 16'h0100, 16'h0302; exactly 256 writes per block; sd_address = START_ADDR+512 after block 1.
- fifo_data_count held at FIFO_DEPTH-255 -> no sd_rd issued; drop it to FIFO_DEPTH-256 -> sd_rd asserted within 2 cycles.
- enable dropped at byte 100 of a block -> all 512 bytes still packed (256 writes), then state IDLE, busy = 0.
- FIFO empty for 3 sample ticks -> underrun_count = 3, no fifo_rd_en; FIFO non-empty -> fifo_rd_en every 567 cycles, pcm_valid one cycle later.
- END_ADDR = START_ADDR+512 -> two blocks, then done = 1 (macro off) or sd_address back to START_ADDR (SD_STREAM_LOOP_EN on).
- rst_n asserted mid-RECV -> all outputs at reset values immediately (asynchronous); the next enable restarts at START_ADDR.
